mprj_marker_checker: RTL and testbench

//  Synthesizable self-check monitor for firmware-driven Caravel tests. Watches a

---
 rtl/mprj_marker_checker.sv | 276 +++++++++++++++++++++++++++
 tb/tb_mprj_marker_checker.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mprj_marker_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mprj_marker_checker
//  Description : Firmware marker monitor for Caravel tests. Tracks an ordered
//                list of checkpoint codes on the marker field, flags error
//                codes and a RUN-cycle timeout, and measures the START->END
//                byte-code latency with a captured result byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module mprj_marker_checker #(
  parameter int         MARK_W      = 16,
  parameter int         NUM_STEPS   = 5,
  parameter int         NUM_ERR     = 2,
  parameter int         TIMEOUT_CYC = 2500000,
  parameter int         LAT_W       = 32,
  parameter logic [7:0] START_CODE  = 8'hA5,
  parameter logic [7:0] END_CODE    = 8'h5A
) (
  input  logic                                        clock,
  input  logic                                        resetb,
  input  logic                                        enable,
  input  logic [MARK_W-1:0]                           marks,
  input  logic [7:0]                                  lat_mark,
  input  logic [NUM_STEPS*MARK_W-1:0]                 exp_marks,
  input  logic [NUM_ERR*MARK_W-1:0]                   err_marks,
  output logic [$clog2(NUM_STEPS+1)-1:0]              step_idx,
  output logic                                        step_hit,
  output logic                                        pass,
  output logic                                        fail,
  output logic [1:0]                                  fail_cause,
  output logic [((NUM_ERR > 1) ? $clog2(NUM_ERR) : 1)-1:0] err_idx,
  output logic [LAT_W-1:0]                            latency,
  output logic                                        lat_valid,
  output logic [7:0]                                  end_data
);

  localparam int c_SI_W  = $clog2(NUM_STEPS + 1);
  localparam int c_EI_W  = (NUM_ERR > 1) ? $clog2(NUM_ERR) : 1;
  localparam int c_TMR_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [c_SI_W-1:0]  c_STEP_LAST = c_SI_W'(NUM_STEPS - 1);
  localparam logic [c_TMR_W-1:0] c_TMO_LAST  = c_TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [c_TMR_W-1:0] c_TMR_MAX   = c_TMR_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    L_IDLE  = 2'd0,
    L_COUNT = 2'd1,
    L_DONE  = 2'd2
  } lstate_t;

  // Registered copies of the marker inputs; every decision uses these
  logic [MARK_W-1:0] r_marks_q;
  logic [MARK_W-1:0] r_marks_prev;
  logic [7:0]        r_lat_q;

  state_t  r_state,  w_state_nxt;
  lstate_t r_lstate, w_lstate_nxt;

  logic [c_TMR_W-1:0] r_timer,     w_timer_nxt;
  logic               r_first,     w_first_nxt;
  logic [LAT_W-1:0]   r_cnt,       w_cnt_nxt;
  logic [c_SI_W-1:0]  r_step_idx,  w_step_idx_nxt;
  logic               r_step_hit,  w_step_hit_nxt;
  logic               r_pass,      w_pass_nxt;
  logic               r_fail,      w_fail_nxt;
  logic [1:0]         r_cause,     w_cause_nxt;
  logic [c_EI_W-1:0]  r_err_idx,   w_err_idx_nxt;
  logic [LAT_W-1:0]   r_latency,   w_latency_nxt;
  logic               r_lat_valid, w_lat_valid_nxt;
  logic [7:0]         r_end_data,  w_end_data_nxt;

  logic [MARK_W-1:0]  w_exp_cur;
  logic               w_err_hit;
  logic [c_EI_W-1:0]  w_err_sel;
  logic               w_step_match;
  logic               w_timeout;
  logic [LAT_W-1:0]   w_cnt_inc;
  logic [c_TMR_W-1:0] w_timer_inc;

  // Capture marker fields and keep the previous registered marker value
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_marks_q    <= '0;
      r_marks_prev <= '0;
      r_lat_q      <= '0;
    end else begin
      r_marks_q    <= marks;
      r_marks_prev <= r_marks_q;
      r_lat_q      <= lat_mark;
    end
  end

  // Expected code for the step currently being waited on
  always_comb begin
    w_exp_cur = '0;
    for (int k = 0; k < NUM_STEPS; k++) begin
      if (r_step_idx == c_SI_W'(k)) w_exp_cur = exp_marks[k*MARK_W +: MARK_W];
    end
  end

  // Error-code match; scanning downwards leaves the lowest matching index
  always_comb begin
    w_err_hit = 1'b0;
    w_err_sel = '0;
    for (int i = NUM_ERR - 1; i >= 0; i--) begin
      if (r_marks_q == err_marks[i*MARK_W +: MARK_W]) begin
        w_err_hit = 1'b1;
        w_err_sel = c_EI_W'(i);
      end
    end
  end

  // A held marker value may only satisfy one step: require a change,
  // except on the first RUN cycle where no earlier RUN value exists.
  assign w_step_match = (r_marks_q == w_exp_cur) &&
                        ((r_marks_q != r_marks_prev) || r_first);
  // Inclusive compare so a step landing on the deadline cycle still times out next cycle
  assign w_timeout    = (r_timer >= c_TMO_LAST);
  assign w_cnt_inc    = (&r_cnt) ? r_cnt : r_cnt + LAT_W'(1);
  assign w_timer_inc  = (r_timer >= c_TMR_MAX) ? r_timer : r_timer + c_TMR_W'(1);

  // Next-state and next-output logic for the checker and latency unit
  always_comb begin
    w_state_nxt     = r_state;
    w_lstate_nxt    = r_lstate;
    w_timer_nxt     = r_timer;
    w_first_nxt     = r_first;
    w_cnt_nxt       = r_cnt;
    w_step_idx_nxt  = r_step_idx;
    w_step_hit_nxt  = 1'b0;
    w_pass_nxt      = r_pass;
    w_fail_nxt      = r_fail;
    w_cause_nxt     = r_cause;
    w_err_idx_nxt   = r_err_idx;
    w_latency_nxt   = r_latency;
    w_lat_valid_nxt = r_lat_valid;
    w_end_data_nxt  = r_end_data;

    case (r_state)
      S_IDLE: begin
        w_lstate_nxt    = L_IDLE;
        w_timer_nxt     = '0;
        w_first_nxt     = 1'b1;
        w_cnt_nxt       = '0;
        w_step_idx_nxt  = '0;
        w_pass_nxt      = 1'b0;
        w_fail_nxt      = 1'b0;
        w_cause_nxt     = 2'd0;
        w_err_idx_nxt   = '0;
        w_latency_nxt   = '0;
        w_lat_valid_nxt = 1'b0;
        w_end_data_nxt  = '0;
        if (enable) w_state_nxt = S_RUN;
      end

      S_RUN: begin
        if (!enable) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_first_nxt = 1'b0;
          w_timer_nxt = w_timer_inc;

          if (w_err_hit) begin
            w_state_nxt   = S_FAIL;
            w_fail_nxt    = 1'b1;
            w_cause_nxt   = 2'd1;
            w_err_idx_nxt = w_err_sel;
          end else if (w_step_match) begin
            w_step_idx_nxt = r_step_idx + c_SI_W'(1);
            w_step_hit_nxt = 1'b1;
            if (r_step_idx == c_STEP_LAST) begin
              w_state_nxt = S_PASS;
              w_pass_nxt  = 1'b1;
            end
          end else if (w_timeout) begin
            w_state_nxt = S_FAIL;
            w_fail_nxt  = 1'b1;
            w_cause_nxt = 2'd2;
          end

          case (r_lstate)
            L_IDLE: begin
              if (r_lat_q == START_CODE) begin
                w_lstate_nxt = L_COUNT;
                w_cnt_nxt    = '0;
              end
            end
            L_COUNT: begin
              // Latency includes the END cycle itself: START at t, END at t+N gives N
              if (r_lat_q == START_CODE) begin
                w_cnt_nxt = '0;
              end else if (r_lat_q == END_CODE) begin
                w_latency_nxt   = w_cnt_inc;
                w_end_data_nxt  = r_marks_q[MARK_W-1 -: 8];
                w_lat_valid_nxt = 1'b1;
                w_lstate_nxt    = L_DONE;
              end else begin
                w_cnt_nxt = w_cnt_inc;
              end
            end
            L_DONE:  w_lstate_nxt = L_DONE;
            default: w_lstate_nxt = L_IDLE;
          endcase
        end
      end

      S_PASS, S_FAIL: begin
        if (!enable) w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State registers for the main checker and latency unit
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state  <= S_IDLE;
      r_lstate <= L_IDLE;
    end else begin
      r_state  <= w_state_nxt;
      r_lstate <= w_lstate_nxt;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_timer     <= '0;
      r_first     <= 1'b0;
      r_cnt       <= '0;
      r_step_idx  <= '0;
      r_step_hit  <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_cause     <= 2'd0;
      r_err_idx   <= '0;
      r_latency   <= '0;
      r_lat_valid <= 1'b0;
      r_end_data  <= '0;
    end else begin
      r_timer     <= w_timer_nxt;
      r_first     <= w_first_nxt;
      r_cnt       <= w_cnt_nxt;
      r_step_idx  <= w_step_idx_nxt;
      r_step_hit  <= w_step_hit_nxt;
      r_pass      <= w_pass_nxt;
      r_fail      <= w_fail_nxt;
      r_cause     <= w_cause_nxt;
      r_err_idx   <= w_err_idx_nxt;
      r_latency   <= w_latency_nxt;
      r_lat_valid <= w_lat_valid_nxt;
      r_end_data  <= w_end_data_nxt;
    end
  end

  assign step_idx   = r_step_idx;
  assign step_hit   = r_step_hit;
  assign pass       = r_pass;
  assign fail       = r_fail;
  assign fail_cause = r_cause;
  assign err_idx    = r_err_idx;
  assign latency    = r_latency;
  assign lat_valid  = r_lat_valid;
  assign end_data   = r_end_data;

endmodule
`default_nettype wire

// File: tb/tb_mprj_marker_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mprj_marker_checker
//  Description : Self-checking bench for mprj_marker_checker; step hits are
//                matched against a queue of expected step indices.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mprj_marker_checker;

  localparam int MARK_W      = 16;
  localparam int NUM_STEPS   = 5;
  localparam int NUM_ERR     = 2;
  localparam int TIMEOUT_CYC = 1200;
  localparam int LAT_W       = 32;

  logic                          clock;
  logic                          resetb;
  logic                          enable;
  logic [MARK_W-1:0]             marks;
  logic [7:0]                    lat_mark;
  logic [NUM_STEPS*MARK_W-1:0]   exp_marks;
  logic [NUM_ERR*MARK_W-1:0]     err_marks;
  logic [2:0]                    step_idx;
  logic                          step_hit;
  logic                          pass;
  logic                          fail;
  logic [1:0]                    fail_cause;
  logic [0:0]                    err_idx;
  logic [LAT_W-1:0]              latency;
  logic                          lat_valid;
  logic [7:0]                    end_data;

  mprj_marker_checker #(
    .MARK_W      (MARK_W),
    .NUM_STEPS   (NUM_STEPS),
    .NUM_ERR     (NUM_ERR),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .LAT_W       (LAT_W)
  ) u_dut (
    .clock      (clock),
    .resetb     (resetb),
    .enable     (enable),
    .marks      (marks),
    .lat_mark   (lat_mark),
    .exp_marks  (exp_marks),
    .err_marks  (err_marks),
    .step_idx   (step_idx),
    .step_hit   (step_hit),
    .pass       (pass),
    .fail       (fail),
    .fail_cause (fail_cause),
    .err_idx    (err_idx),
    .latency    (latency),
    .lat_valid  (lat_valid),
    .end_data   (end_data)
  );

  localparam logic [NUM_STEPS*MARK_W-1:0] c_EXP_STD =
    {16'hAB53, 16'hAB52, 16'hAB51, 16'hABA0, 16'hAB40};
  localparam logic [NUM_ERR*MARK_W-1:0] c_ERR_STD = {16'hABD0, 16'hABC0};

  logic [15:0] codes [NUM_STEPS];

  int n_checks = 0;
  int n_fail   = 0;
  int sb[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clocks and return just after the last rising edge
  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Return to IDLE, clear inputs, then arm again
  task automatic restart();
    enable   = 1'b0;
    marks    = '0;
    lat_mark = '0;
    cycles(3);
    enable = 1'b1;
  endtask

  task automatic drive_step(input logic [15:0] code, input int exp_idx, input int hold);
    marks = code;
    sb.push_back(exp_idx);
    cycles(hold);
  endtask

  // Scoreboard: every step_hit pulse must match the oldest expected index
  always @(negedge clock) begin
    if (resetb && step_hit) begin
      if (sb.size() == 0) check("hit_expected", 64'(sb.size()), 64'd1);
      else                check("hit_idx", 64'(step_idx), 64'(sb.pop_front()));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    codes[0] = 16'hAB40; codes[1] = 16'hABA0; codes[2] = 16'hAB51;
    codes[3] = 16'hAB52; codes[4] = 16'hAB53;
    resetb    = 1'b0;
    enable    = 1'b0;
    marks     = '0;
    lat_mark  = '0;
    exp_marks = c_EXP_STD;
    err_marks = c_ERR_STD;
    cycles(3);
    check("rst_step_idx",  64'(step_idx),   64'd0);
    check("rst_pass",      64'(pass),       64'd0);
    check("rst_fail",      64'(fail),       64'd0);
    check("rst_latency",   64'(latency),    64'd0);
    check("rst_lat_valid", 64'(lat_valid),  64'd0);
    resetb = 1'b1;
    cycles(2);

    // Full ordered sequence, pass two cycles after the final code
    restart();
    cycles(5);
    for (int k = 0; k < NUM_STEPS - 1; k++) drive_step(codes[k], k + 1, 100);
    marks = codes[4];
    sb.push_back(5);
    @(posedge clock); @(negedge clock);
    check("pass_1cyc", 64'(pass), 64'd0);
    @(posedge clock); @(negedge clock);
    check("pass_2cyc", 64'(pass), 64'd1);
    cycles(98);
    check("seq_step_idx", 64'(step_idx), 64'd5);
    check("seq_fail",     64'(fail),     64'd0);
    check("seq_sb",       64'(sb.size()), 64'd0);
    marks = 16'hABC0;
    cycles(3);
    check("pass_ignores_err", 64'(fail), 64'd0);

    // Error codes 0 and 1
    restart();
    drive_step(16'hAB40, 1, 5);
    marks = 16'hABC0;
    cycles(5);
    check("err0_fail",  64'(fail),       64'd1);
    check("err0_cause", 64'(fail_cause), 64'd1);
    check("err0_idx",   64'(err_idx),    64'd0);
    check("err0_step",  64'(step_idx),   64'd1);
    restart();
    drive_step(16'hAB40, 1, 5);
    marks = 16'hABD0;
    cycles(5);
    check("err1_idx",   64'(err_idx),    64'd1);
    check("err1_cause", 64'(fail_cause), 64'd1);

    // Error wins over a step match on the same code
    err_marks = {16'hABA0, 16'hABC0};
    restart();
    drive_step(16'hAB40, 1, 5);
    marks = 16'hABA0;
    cycles(5);
    check("errprio_fail", 64'(fail),     64'd1);
    check("errprio_idx",  64'(err_idx),  64'd1);
    check("errprio_step", 64'(step_idx), 64'd1);
    err_marks = c_ERR_STD;

    // Timeout while holding the first code
    restart();
    marks = 16'hAB40;
    sb.push_back(1);
    cycles(TIMEOUT_CYC);
    @(negedge clock);
    check("tmo_early", 64'(fail), 64'd0);
    @(posedge clock); @(negedge clock);
    check("tmo_fail",  64'(fail),       64'd1);
    check("tmo_cause", 64'(fail_cause), 64'd2);
    check("tmo_step",  64'(step_idx),   64'd1);
    cycles(1);

    // Repeated expected codes: a held value counts once
    exp_marks = {16'hAB53, 16'hAB52, 16'hAB51, 16'hAB40, 16'hAB40};
    restart();
    drive_step(16'hAB40, 1, 20);
    check("dup_hold", 64'(step_idx), 64'd1);
    marks = 16'h0000;
    cycles(3);
    drive_step(16'hAB40, 2, 5);
    check("dup_retoggle", 64'(step_idx), 64'd2);
    exp_marks = c_EXP_STD;

    // Latency: stray END ignored, repeated START restarts the count
    restart();
    lat_mark = 8'h5A; cycles(1); lat_mark = 8'h00; cycles(5);
    check("lat_stray_end", 64'(lat_valid), 64'd0);
    lat_mark = 8'hA5; cycles(1); lat_mark = 8'h00; cycles(19);
    lat_mark = 8'hA5; cycles(1); lat_mark = 8'h00; cycles(29);
    lat_mark = 8'h5A; marks = 16'h7E00; cycles(1); lat_mark = 8'h00; cycles(3);
    check("lat_restart",    64'(latency),   64'd30);
    check("lat_restart_ed", 64'(end_data),  64'h7E);
    check("lat_restart_v",  64'(lat_valid), 64'd1);

    restart();
    cycles(10);
    lat_mark = 8'hA5; cycles(1); lat_mark = 8'h00; cycles(999);
    lat_mark = 8'h5A; marks = 16'h3C00; cycles(1); lat_mark = 8'h00; cycles(3);
    check("lat_1000",    64'(latency),   64'd1000);
    check("lat_end_dat", 64'(end_data),  64'h3C);
    check("lat_valid",   64'(lat_valid), 64'd1);

    // Asynchronous reset mid-run, then rerun to PASS and release enable
    restart();
    drive_step(16'hAB40, 1, 5);
    drive_step(16'hABA0, 2, 5);
    drive_step(16'hAB51, 3, 5);
    check("pre_rst_step", 64'(step_idx), 64'd3);
    @(negedge clock);
    #2 resetb = 1'b0;
    #1;
    check("arst_step",  64'(step_idx), 64'd0);
    check("arst_pass",  64'(pass),     64'd0);
    check("arst_fail",  64'(fail),     64'd0);
    check("arst_lat",   64'(latency),  64'd0);
    resetb = 1'b1;
    cycles(2);
    restart();
    drive_step(16'hAB40, 1, 5);
    check("rerun_step", 64'(step_idx), 64'd1);
    for (int k = 1; k < NUM_STEPS; k++) drive_step(codes[k], k + 1, 5);
    check("rerun_pass", 64'(pass), 64'd1);
    enable = 1'b0;
    cycles(3);
    check("idle_pass_clr", 64'(pass),     64'd0);
    check("idle_step_clr", 64'(step_idx), 64'd0);
    check("final_sb",      64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
